set_field_multi: RTL and testbench
==================================

Name: set_field_multi

Overview:
- Parametrised successor to the single-field setter in the l3fwd action pipe.
- Overwrites up to NUM_FIELDS byte-aligned header fields at runtime-programmable byte offsets, anywhere in a multi-beat Avalon-ST packet. Fields may straddle beat boundaries.
- Field values, offsets and enables are latched per packet at the start-of-packet beat.
- Sits between the match stage and the egress deparser. One registered output stage.

Parameters:
DATA_WIDTH, 512, stream data width in bits; multiple of 8
EMPTY_WIDTH, $clog2(DATA_WIDTH/8), empty field width
CHANNEL_WIDTH, 6, channel sideband width
ERROR_WIDTH, 4, error sideband width
NUM_FIELDS, 4, number of independently settable fields
FIELD_BYTES, 6, bytes per field (fixed for all fields)
OFFSET_WIDTH, 8, width of byte-offset inputs; packet byte range covered is 0 .. 2^OFFSET_WIDTH-1
BEAT_CNT_WIDTH, OFFSET_WIDTH, width of the internal beat counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
field_data  in  NUM_FIELDS*FIELD_BYTES*8  field i value at slice i; most significant byte is written first
field_offset  in  NUM_FIELDS*OFFSET_WIDTH  field i start byte, absolute from packet byte 0
field_en  in  NUM_FIELDS  per-field enable
stream_in_data  in  DATA_WIDTH  input data; packet byte 0 of a beat is data[DATA_WIDTH-1 -: 8]
stream_in_empty  in  EMPTY_WIDTH  unused bytes on the EOP beat (low-order lanes)
stream_in_valid  in  1  input valid
stream_in_ready  out  1  input ready
stream_in_startofpacket  in  1  SOP
stream_in_endofpacket  in  1  EOP
stream_in_channel  in  CHANNEL_WIDTH  channel
stream_in_error  in  ERROR_WIDTH  error
stream_out_data  out  DATA_WIDTH  modified data
stream_out_empty  out  EMPTY_WIDTH  passed through
stream_out_valid  out  1  output valid
stream_out_ready  in  1  output ready
stream_out_startofpacket  out  1  SOP
stream_out_endofpacket  out  1  EOP
stream_out_channel  out  CHANNEL_WIDTH  channel
stream_out_error  out  ERROR_WIDTH  error

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: all output registers 0, including data, empty, valid, SOP, EOP, channel and error. The beat counter and latched field set are also 0.
- Handshake:
  - stream_in_ready = !stream_out_valid || stream_out_ready.
  - Latency is 1 cycle, with full throughput.
  - The output holds stable while valid && !ready.
- Latching the field set: on an accepted SOP beat, field_data, field_offset and field_en are latched. The SOP beat itself uses the live inputs; later beats use the latched copy. Changes to the inputs mid-packet have no effect.
- Beat counter:
  - 0 on the SOP beat; +1 per accepted non-SOP beat.
  - Saturates at all-ones. Once saturated, no further fields are written.
  - An SOP beat resets it to 0 regardless of whether the previous packet saw EOP.
- Byte replacement:
  - For lane j of beat k, the absolute byte is a = k*(DATA_WIDTH/8) + j.
  - If field_en[i] and field_offset[i] <= a < field_offset[i]+FIELD_BYTES, the lane is replaced by field i byte (a - field_offset[i]).
  - If fields overlap, the highest index wins.
  - Offset arithmetic uses OFFSET_WIDTH+1 bits, so an offset near the maximum does not wrap to low bytes.
- Lanes are not modified when:
  - they are in the empty region of the EOP beat (j >= DATA_WIDTH/8 - empty);
  - no field covers them.
- Sideband: empty, channel, SOP and EOP pass through unchanged. Error passes through unchanged unless the optional feature is enabled.
- Packet shorter than the field: only the bytes that exist are written; nothing is inserted.
- Reset mid-packet: the output drops immediately. The next accepted beat is treated as packet data only once an SOP is seen; any non-SOP beats before that are passed through unmodified, with the beat counter held at all-ones.

Optional Feature:
SET_FIELD_TRUNC_ERR_EN
- Defined: keep a per-packet record of enabled fields whose last byte was not written before EOP, i.e. truncated or absent. On the EOP beat, stream_out_error[0] = stream_in_error[0] | (any enabled field incomplete).
- Undefined: no tracking logic; the error field passes through unchanged.

Decomposition:
- Package set_field_pkg:
  - BYTE_W = 8;
  - a field-descriptor struct {en, offset, data};
  - a function lane_hit(offset, beat, lane).
- Sub-module set_field_lane_mux: one byte lane, NUM_FIELDS comparators plus a priority mux. Generated DATA_WIDTH/8 times.

Test Plan:
1. Defaults, 2-beat packet, field0 en, offset 12, data 0x112233445566 -> output beat0 bytes 12..17 = 11 22 33 44 55 66; other bytes unchanged; latency 1.
2. Straddle: field0 offset 62, DATA_WIDTH=512 -> beat0 bytes 62,63 = 11,22; beat1 bytes 0..3 = 33,44,55,66.
3. Overlap: field0 offset 10 data all-AA, field3 offset 12 data all-BB -> bytes 10,11 = AA; bytes 12..17 = BB.
4. Backpressure: stream_out_ready low 5 cycles mid-packet, field inputs changed meanwhile -> output held stable; later beats use the SOP-latched values; no beat lost or duplicated.
5. Short packet: 1 beat, empty=50, field0 offset 10 -> bytes 10..13 written, bytes 14,15 untouched; with SET_FIELD_TRUNC_ERR_EN, error[0]=1 on EOP, else error unchanged.
6. rst_n asserted mid-packet -> all outputs 0 immediately; after release, a new SOP packet is modified correctly from beat 0.

Source files
------------

// File: rtl/set_field_pkg.sv
// Shared types and helpers for the multi-field header setter.
// FIELD_BYTES*8 must not exceed FD_MAX_DATA_W and OFFSET_WIDTH must not exceed FD_MAX_OFFSET_W.
package set_field_pkg;

   localparam int BYTE_W          = 8;
   localparam int FD_MAX_OFFSET_W = 16;
   localparam int FD_MAX_DATA_W   = 256;

   typedef struct packed {
      logic                       en;
      logic [FD_MAX_OFFSET_W-1:0] offset;
      logic [FD_MAX_DATA_W-1:0]   data;
   } field_desc_t;

   // True when lane of the given beat falls inside [offset, offset+field_bytes).
   // The arithmetic is done in 32 bits, so a field near the top of the offset range never wraps to low bytes.
   function automatic logic lane_hit(input int unsigned offset,
                                     input int unsigned beat,
                                     input int unsigned lane,
                                     input int unsigned beat_bytes,
                                     input int unsigned field_bytes);
      int unsigned abs_byte;
      abs_byte = beat * beat_bytes + lane;
      lane_hit = (abs_byte >= offset) && (abs_byte < offset + field_bytes);
   endfunction

endpackage

// File: rtl/set_field_lane_mux.sv
// One byte lane: per-field range compare and a priority mux, where the highest field index wins.
module set_field_lane_mux
   import set_field_pkg::*;
#(
   parameter int NUM_FIELDS     = 4,
   parameter int FIELD_BYTES    = 6,
   parameter int BEAT_BYTES     = 64,
   parameter int LANE           = 0,
   parameter int BEAT_CNT_WIDTH = 8
) (
   input  field_desc_t [NUM_FIELDS-1:0] fields,
   input  logic [BEAT_CNT_WIDTH-1:0]    beat,
   input  logic                         write_en,
   input  logic [BYTE_W-1:0]            byte_in,
   output logic [BYTE_W-1:0]            byte_out,
   output logic [NUM_FIELDS-1:0]        last_hit
);

   // Select the replacement byte; last_hit flags the lane carrying a field's final byte
   always_comb begin
      int unsigned rel_v;
      byte_out = byte_in;
      last_hit = {NUM_FIELDS{1'b0}};
      rel_v    = 32'd0;
      for (int i = 0; i < NUM_FIELDS; i++) begin
         if (write_en && fields[i].en &&
             lane_hit(32'(fields[i].offset), 32'(beat), LANE, BEAT_BYTES, FIELD_BYTES)) begin
            rel_v       = 32'(beat) * BEAT_BYTES + LANE - 32'(fields[i].offset);
            byte_out    = fields[i].data[(FIELD_BYTES - 1 - rel_v) * BYTE_W +: BYTE_W];
            last_hit[i] = (rel_v == FIELD_BYTES - 1);
         end else begin
            last_hit[i] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/set_field_multi.sv
// Overwrites up to NUM_FIELDS byte-aligned header fields anywhere in a multi-beat Avalon-ST packet.
// Optional macro SET_FIELD_TRUNC_ERR_EN: flag enabled fields left incomplete at EOP on error[0].
module set_field_multi
   import set_field_pkg::*;
#(
   parameter int DATA_WIDTH     = 512,
   parameter int EMPTY_WIDTH    = $clog2(DATA_WIDTH/8),
   parameter int CHANNEL_WIDTH  = 6,
   parameter int ERROR_WIDTH    = 4,
   parameter int NUM_FIELDS     = 4,
   parameter int FIELD_BYTES    = 6,
   parameter int OFFSET_WIDTH   = 8,
   parameter int BEAT_CNT_WIDTH = OFFSET_WIDTH
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [NUM_FIELDS*FIELD_BYTES*8-1:0]   field_data,
   input  logic [NUM_FIELDS*OFFSET_WIDTH-1:0]    field_offset,
   input  logic [NUM_FIELDS-1:0]                 field_en,
   input  logic [DATA_WIDTH-1:0]                 stream_in_data,
   input  logic [EMPTY_WIDTH-1:0]                stream_in_empty,
   input  logic                                  stream_in_valid,
   output logic                                  stream_in_ready,
   input  logic                                  stream_in_startofpacket,
   input  logic                                  stream_in_endofpacket,
   input  logic [CHANNEL_WIDTH-1:0]              stream_in_channel,
   input  logic [ERROR_WIDTH-1:0]                stream_in_error,
   output logic [DATA_WIDTH-1:0]                 stream_out_data,
   output logic [EMPTY_WIDTH-1:0]                stream_out_empty,
   output logic                                  stream_out_valid,
   input  logic                                  stream_out_ready,
   output logic                                  stream_out_startofpacket,
   output logic                                  stream_out_endofpacket,
   output logic [CHANNEL_WIDTH-1:0]              stream_out_channel,
   output logic [ERROR_WIDTH-1:0]                stream_out_error
);

   localparam int BEAT_BYTES = DATA_WIDTH / BYTE_W;
   localparam logic [BEAT_CNT_WIDTH-1:0] CNT_MAX  = {BEAT_CNT_WIDTH{1'b1}};
   localparam logic [BEAT_CNT_WIDTH-1:0] CNT_ZERO = {BEAT_CNT_WIDTH{1'b0}};
   localparam logic [BEAT_CNT_WIDTH-1:0] CNT_ONE  = {{(BEAT_CNT_WIDTH-1){1'b0}}, 1'b1};

   field_desc_t [NUM_FIELDS-1:0]          live_fields_s;
   field_desc_t [NUM_FIELDS-1:0]          use_fields_s;
   field_desc_t [NUM_FIELDS-1:0]          fields_r;
   logic [BEAT_CNT_WIDTH-1:0]             beat_cnt_r;
   logic [BEAT_CNT_WIDTH-1:0]             cur_beat_s;
   logic                                  in_pkt_r;
   logic                                  pkt_active_s;
   logic                                  write_ok_s;
   logic                                  accept_s;
   logic [DATA_WIDTH-1:0]                 data_mod_s;
   logic [BEAT_BYTES*NUM_FIELDS-1:0]      last_hit_s;
   logic [ERROR_WIDTH-1:0]                err_next_s;

   assign stream_in_ready = !stream_out_valid || stream_out_ready;
   assign accept_s        = stream_in_valid && stream_in_ready;

   // Zero-extend the live field ports into descriptors
   always_comb begin
      live_fields_s = '0;
      for (int i = 0; i < NUM_FIELDS; i++) begin
         live_fields_s[i].en     = field_en[i];
         live_fields_s[i].offset = FD_MAX_OFFSET_W'(field_offset[i*OFFSET_WIDTH +: OFFSET_WIDTH]);
         live_fields_s[i].data   = FD_MAX_DATA_W'(field_data[i*FIELD_BYTES*BYTE_W +: FIELD_BYTES*BYTE_W]);
      end
   end

   // SOP beat uses live inputs, later beats the copy latched at SOP
   always_comb begin
      if (stream_in_startofpacket) begin
         use_fields_s = live_fields_s;
      end else begin
         use_fields_s = fields_r;
      end
   end

   // Index of the beat currently on the input, saturating at all-ones
   always_comb begin
      if (stream_in_startofpacket) begin
         cur_beat_s = CNT_ZERO;
      end else if (beat_cnt_r == CNT_MAX) begin
         cur_beat_s = CNT_MAX;
      end else begin
         cur_beat_s = beat_cnt_r + CNT_ONE;
      end
   end

   assign pkt_active_s = stream_in_startofpacket || in_pkt_r;
   assign write_ok_s   = pkt_active_s && (cur_beat_s != CNT_MAX);

   for (genvar j = 0; j < BEAT_BYTES; j++) begin : g_lane
      logic lane_ok_s;
      assign lane_ok_s = write_ok_s &&
                         (!stream_in_endofpacket || (32'(j) + 32'(stream_in_empty) < 32'(BEAT_BYTES)));
      set_field_lane_mux #(
         .NUM_FIELDS     (NUM_FIELDS),
         .FIELD_BYTES    (FIELD_BYTES),
         .BEAT_BYTES     (BEAT_BYTES),
         .LANE           (j),
         .BEAT_CNT_WIDTH (BEAT_CNT_WIDTH)
      ) u_lane (
         .fields   (use_fields_s),
         .beat     (cur_beat_s),
         .write_en (lane_ok_s),
         .byte_in  (stream_in_data[DATA_WIDTH-1-j*BYTE_W -: BYTE_W]),
         .byte_out (data_mod_s[DATA_WIDTH-1-j*BYTE_W -: BYTE_W]),
         .last_hit (last_hit_s[j*NUM_FIELDS +: NUM_FIELDS])
      );
   end

`ifdef SET_FIELD_TRUNC_ERR_EN
   logic [NUM_FIELDS-1:0] done_r;
   logic [NUM_FIELDS-1:0] beat_done_s;
   logic [NUM_FIELDS-1:0] done_all_s;
   logic [NUM_FIELDS-1:0] en_used_s;

   // Accumulate which enabled fields have had their final byte written
   always_comb begin
      beat_done_s = {NUM_FIELDS{1'b0}};
      en_used_s   = {NUM_FIELDS{1'b0}};
      for (int j = 0; j < BEAT_BYTES; j++) begin
         beat_done_s = beat_done_s | last_hit_s[j*NUM_FIELDS +: NUM_FIELDS];
      end
      for (int i = 0; i < NUM_FIELDS; i++) begin
         en_used_s[i] = use_fields_s[i].en;
      end
      if (stream_in_startofpacket) begin
         done_all_s = beat_done_s;
      end else begin
         done_all_s = done_r | beat_done_s;
      end
      err_next_s = stream_in_error;
      if (stream_in_endofpacket && pkt_active_s && (|(en_used_s & ~done_all_s))) begin
         err_next_s[0] = 1'b1;
      end else begin
         err_next_s[0] = stream_in_error[0];
      end
   end

   // Per-packet completion record
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_r <= {NUM_FIELDS{1'b0}};
      end else if (accept_s) begin
         done_r <= done_all_s;
      end
   end
`else
   logic unused_last_hit_s;
   assign unused_last_hit_s = ^last_hit_s;
   assign err_next_s        = stream_in_error;
`endif

   // Packet tracking: beat counter, in-packet flag and SOP-latched field set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt_r <= CNT_ZERO;
         in_pkt_r   <= 1'b0;
         fields_r   <= '0;
      end else if (accept_s) begin
         beat_cnt_r <= pkt_active_s ? cur_beat_s : CNT_MAX;
         in_pkt_r   <= pkt_active_s && !stream_in_endofpacket;
         if (stream_in_startofpacket) begin
            fields_r <= live_fields_s;
         end
      end
   end

   // Registered output stage, held while valid && !ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stream_out_valid         <= 1'b0;
         stream_out_data          <= {DATA_WIDTH{1'b0}};
         stream_out_empty         <= {EMPTY_WIDTH{1'b0}};
         stream_out_startofpacket <= 1'b0;
         stream_out_endofpacket   <= 1'b0;
         stream_out_channel       <= {CHANNEL_WIDTH{1'b0}};
         stream_out_error         <= {ERROR_WIDTH{1'b0}};
      end else if (stream_in_ready) begin
         stream_out_valid <= stream_in_valid;
         if (stream_in_valid) begin
            stream_out_data          <= data_mod_s;
            stream_out_empty         <= stream_in_empty;
            stream_out_startofpacket <= stream_in_startofpacket;
            stream_out_endofpacket   <= stream_in_endofpacket;
            stream_out_channel       <= stream_in_channel;
            stream_out_error         <= err_next_s;
         end
      end
   end

endmodule

// File: tb/tb_set_field_multi.sv
// Directed testbench for set_field_multi with hand-computed expected beats.
module tb_set_field_multi;

   localparam int DW = 512;
   localparam int EW = 6;
   localparam int CW = 6;
   localparam int RW = 4;
   localparam int NF = 4;
   localparam int FB = 6;
   localparam int OW = 8;

`ifdef SET_FIELD_TRUNC_ERR_EN
   localparam logic [RW-1:0] TRUNC_ERR = 4'b0001;
`else
   localparam logic [RW-1:0] TRUNC_ERR = 4'b0000;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NF*FB*8-1:0] field_data;
   logic [NF*OW-1:0]  field_offset;
   logic [NF-1:0]     field_en;
   logic [DW-1:0]     stream_in_data;
   logic [EW-1:0]     stream_in_empty;
   logic              stream_in_valid;
   logic              stream_in_ready;
   logic              stream_in_startofpacket;
   logic              stream_in_endofpacket;
   logic [CW-1:0]     stream_in_channel;
   logic [RW-1:0]     stream_in_error;
   logic [DW-1:0]     stream_out_data;
   logic [EW-1:0]     stream_out_empty;
   logic              stream_out_valid;
   logic              stream_out_ready;
   logic              stream_out_startofpacket;
   logic              stream_out_endofpacket;
   logic [CW-1:0]     stream_out_channel;
   logic [RW-1:0]     stream_out_error;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [47:0] VAL = 48'h112233445566;

   always #5 clk = ~clk;

   set_field_multi dut (
      .clk                      (clk),
      .rst_n                    (rst_n),
      .field_data               (field_data),
      .field_offset             (field_offset),
      .field_en                 (field_en),
      .stream_in_data           (stream_in_data),
      .stream_in_empty          (stream_in_empty),
      .stream_in_valid          (stream_in_valid),
      .stream_in_ready          (stream_in_ready),
      .stream_in_startofpacket  (stream_in_startofpacket),
      .stream_in_endofpacket    (stream_in_endofpacket),
      .stream_in_channel        (stream_in_channel),
      .stream_in_error          (stream_in_error),
      .stream_out_data          (stream_out_data),
      .stream_out_empty         (stream_out_empty),
      .stream_out_valid         (stream_out_valid),
      .stream_out_ready         (stream_out_ready),
      .stream_out_startofpacket (stream_out_startofpacket),
      .stream_out_endofpacket   (stream_out_endofpacket),
      .stream_out_channel       (stream_out_channel),
      .stream_out_error         (stream_out_error)
   );

   // Background pattern: lane j of pattern k holds (k*64+j) ^ 0xC3.
   function automatic logic [DW-1:0] pat(input int k);
      logic [DW-1:0] d;
      for (int j = 0; j < 64; j++) d[DW-1-8*j -: 8] = 8'((k*64 + j) ^ 8'hC3);
      return d;
   endfunction

   // Place bytes first..first+count-1 of a 48-bit field value at lanes lane..lane+count-1.
   function automatic logic [DW-1:0] put(input logic [DW-1:0] d, input int lane,
                                         input logic [47:0] v, input int first, input int count);
      logic [DW-1:0] r;
      r = d;
      for (int n = 0; n < count; n++) r[DW-1-8*(lane+n) -: 8] = v[47-8*(first+n) -: 8];
      return r;
   endfunction

   task automatic set_field(input int i, input logic [OW-1:0] off, input logic [47:0] v, input logic en);
      field_data[i*48 +: 48]  = v;
      field_offset[i*OW +: OW] = off;
      field_en[i]              = en;
   endtask

   task automatic clear_fields();
      field_data   = '0;
      field_offset = '0;
      field_en     = '0;
   endtask

   task automatic send(input logic [DW-1:0] d, input logic sop, input logic eop,
                       input logic [EW-1:0] emp, input logic [RW-1:0] err, input logic [CW-1:0] ch);
      int waited = 0;
      stream_in_data          = d;
      stream_in_startofpacket = sop;
      stream_in_endofpacket   = eop;
      stream_in_empty         = emp;
      stream_in_error         = err;
      stream_in_channel       = ch;
      stream_in_valid         = 1'b1;
      while (!stream_in_ready && waited < 50) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!stream_in_ready) begin
         n_checks++; n_fail++;
         $display("FAIL send_timeout ready=%0b required 1", stream_in_ready);
      end
      @(posedge clk); #1;
      stream_in_valid = 1'b0;
   endtask

   task automatic test_reset();
      n_checks++; if (stream_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", stream_out_valid); end
      n_checks++; if (stream_out_data !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", stream_out_data); end
      n_checks++; if ({stream_out_startofpacket, stream_out_endofpacket, stream_out_empty, stream_out_channel, stream_out_error} !== '0) begin
         n_fail++; $display("FAIL reset_sideband got %b want 0", {stream_out_startofpacket, stream_out_endofpacket, stream_out_empty, stream_out_channel, stream_out_error}); end
      n_checks++; if (stream_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0b want 1", stream_in_ready); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      logic [DW-1:0] exp;
      clear_fields();
      set_field(0, 8'd12, VAL, 1'b1);
      n_checks++; if (stream_out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle_valid got %0b want 0", stream_out_valid); end
      send(pat(0), 1'b1, 1'b0, 6'd0, 4'b1010, 6'h2A);
      exp = put(pat(0), 12, VAL, 0, 6);
      n_checks++; if (stream_out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency_valid got %0b want 1", stream_out_valid); end
      n_checks++; if (stream_out_data !== exp) begin n_fail++; $display("FAIL basic_beat0_data got %h want %h", stream_out_data, exp); end
      n_checks++; if ({stream_out_startofpacket, stream_out_channel, stream_out_error} !== {1'b1, 6'h2A, 4'b1010}) begin
         n_fail++; $display("FAIL basic_sideband got %b want %b", {stream_out_startofpacket, stream_out_channel, stream_out_error}, {1'b1, 6'h2A, 4'b1010}); end
      send(pat(1), 1'b0, 1'b1, 6'd0, 4'b0000, 6'h2A);
      n_checks++; if (stream_out_data !== pat(1)) begin n_fail++; $display("FAIL basic_beat1_data got %h want %h", stream_out_data, pat(1)); end
      n_checks++; if ({stream_out_endofpacket, stream_out_error} !== {1'b1, 4'b0000}) begin
         n_fail++; $display("FAIL basic_eop got %b want %b", {stream_out_endofpacket, stream_out_error}, {1'b1, 4'b0000}); end
   endtask

   task automatic test_straddle();
      logic [DW-1:0] exp;
      clear_fields();
      set_field(0, 8'd62, VAL, 1'b1);
      send(pat(0), 1'b1, 1'b0, 6'd0, 4'b0000, 6'h01);
      exp = put(pat(0), 62, VAL, 0, 2);
      n_checks++; if (stream_out_data !== exp) begin n_fail++; $display("FAIL straddle_beat0 got %h want %h", stream_out_data, exp); end
      send(pat(1), 1'b0, 1'b1, 6'd0, 4'b0000, 6'h01);
      exp = put(pat(1), 0, VAL, 2, 4);
      n_checks++; if (stream_out_data !== exp) begin n_fail++; $display("FAIL straddle_beat1 got %h want %h", stream_out_data, exp); end
      n_checks++; if (stream_out_error !== 4'b0000) begin n_fail++; $display("FAIL straddle_error got %b want 0000", stream_out_error); end
   endtask

   task automatic test_overlap();
      logic [DW-1:0] exp;
      clear_fields();
      set_field(0, 8'd10, 48'hAAAAAAAAAAAA, 1'b1);
      set_field(3, 8'd12, 48'hBBBBBBBBBBBB, 1'b1);
      send(pat(2), 1'b1, 1'b1, 6'd0, 4'b0000, 6'h03);
      exp = put(put(pat(2), 10, 48'hAAAAAAAAAAAA, 0, 2), 12, 48'hBBBBBBBBBBBB, 0, 6);
      n_checks++; if (stream_out_data !== exp) begin n_fail++; $display("FAIL overlap_data got %h want %h", stream_out_data, exp); end
      n_checks++; if (stream_out_error !== 4'b0000) begin n_fail++; $display("FAIL overlap_error got %b want 0000", stream_out_error); end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] exp;
      clear_fields();
      set_field(0, 8'd126, VAL, 1'b1);
      send(pat(0), 1'b1, 1'b0, 6'd0, 4'b0000, 6'h05);
      n_checks++; if (stream_out_data !== pat(0)) begin n_fail++; $display("FAIL bp_beat0 got %h want %h", stream_out_data, pat(0)); end
      stream_out_ready        = 1'b0;
      stream_in_data          = pat(1);
      stream_in_startofpacket = 1'b0;
      stream_in_endofpacket   = 1'b0;
      stream_in_valid         = 1'b1;
      set_field(0, 8'd0, 48'hFFFFFFFFFFFF, 1'b1);
      set_field(1, 8'd64, 48'hEEEEEEEEEEEE, 1'b1);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         n_checks++;
         if (stream_out_valid !== 1'b1 || stream_out_data !== pat(0) || stream_out_startofpacket !== 1'b1 || stream_in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_hold cycle %0d got valid=%0b sop=%0b ready=%0b want 1 1 0", c, stream_out_valid, stream_out_startofpacket, stream_in_ready);
         end
      end
      stream_out_ready = 1'b1;
      @(posedge clk); #1;
      stream_in_valid = 1'b0;
      exp = put(pat(1), 62, VAL, 0, 2);
      n_checks++; if (stream_out_data !== exp || stream_out_startofpacket !== 1'b0) begin
         n_fail++; $display("FAIL bp_beat1 got %h want %h", stream_out_data, exp); end
      send(pat(2), 1'b0, 1'b1, 6'd0, 4'b0000, 6'h05);
      exp = put(pat(2), 0, VAL, 2, 4);
      n_checks++; if (stream_out_data !== exp) begin n_fail++; $display("FAIL bp_beat2 got %h want %h", stream_out_data, exp); end
      n_checks++; if (stream_out_error !== 4'b0000) begin n_fail++; $display("FAIL bp_error got %b want 0000", stream_out_error); end
      @(posedge clk); #1;
      n_checks++; if (stream_out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup got valid=%0b want 0", stream_out_valid); end
   endtask

   task automatic test_short();
      logic [DW-1:0] exp;
      clear_fields();
      set_field(0, 8'd10, VAL, 1'b1);
      send(pat(3), 1'b1, 1'b1, 6'd50, 4'b0000, 6'h07);
      exp = put(pat(3), 10, VAL, 0, 4);
      n_checks++; if (stream_out_data !== exp) begin n_fail++; $display("FAIL short_data got %h want %h", stream_out_data, exp); end
      n_checks++; if (stream_out_empty !== 6'd50) begin n_fail++; $display("FAIL short_empty got %0d want 50", stream_out_empty); end
      n_checks++; if (stream_out_error !== TRUNC_ERR) begin n_fail++; $display("FAIL short_error got %b want %b", stream_out_error, TRUNC_ERR); end
   endtask

   task automatic test_high_offset();
      clear_fields();
      set_field(0, 8'd254, VAL, 1'b1);
      send(pat(0), 1'b1, 1'b1, 6'd0, 4'b0000, 6'h09);
      n_checks++; if (stream_out_data !== pat(0)) begin n_fail++; $display("FAIL high_offset_data got %h want %h", stream_out_data, pat(0)); end
      n_checks++; if (stream_out_error !== TRUNC_ERR) begin n_fail++; $display("FAIL high_offset_error got %b want %b", stream_out_error, TRUNC_ERR); end
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] exp;
      clear_fields();
      set_field(0, 8'd12, VAL, 1'b1);
      send(pat(0), 1'b1, 1'b0, 6'd0, 4'b0000, 6'h0B);
      exp = put(pat(0), 12, VAL, 0, 6);
      n_checks++; if (stream_out_data !== exp) begin n_fail++; $display("FAIL rstmid_beat0 got %h want %h", stream_out_data, exp); end
      rst_n = 1'b0;
      #1;
      n_checks++; if (stream_out_valid !== 1'b0 || stream_out_data !== '0 || stream_out_startofpacket !== 1'b0 || stream_out_channel !== '0) begin
         n_fail++; $display("FAIL rstmid_async valid=%0b sop=%0b ch=%h want all 0", stream_out_valid, stream_out_startofpacket, stream_out_channel); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      send(pat(1), 1'b0, 1'b1, 6'd0, 4'b0000, 6'h0B);
      n_checks++; if (stream_out_data !== pat(1)) begin n_fail++; $display("FAIL rstmid_orphan got %h want %h", stream_out_data, pat(1)); end
      n_checks++; if (stream_out_error !== 4'b0000) begin n_fail++; $display("FAIL rstmid_orphan_error got %b want 0000", stream_out_error); end
      set_field(0, 8'd20, VAL, 1'b1);
      send(pat(2), 1'b1, 1'b1, 6'd0, 4'b0000, 6'h0C);
      exp = put(pat(2), 20, VAL, 0, 6);
      n_checks++; if (stream_out_data !== exp) begin n_fail++; $display("FAIL rstmid_new_pkt got %h want %h", stream_out_data, exp); end
   endtask

   initial begin
      clear_fields();
      stream_in_data          = '0;
      stream_in_empty         = '0;
      stream_in_valid         = 1'b0;
      stream_in_startofpacket = 1'b0;
      stream_in_endofpacket   = 1'b0;
      stream_in_channel       = '0;
      stream_in_error         = '0;
      stream_out_ready        = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_basic();
      test_straddle();
      test_overlap();
      test_backpressure();
      test_short();
      test_high_offset();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
